// File: rtl/elevator_sched_if.sv
// Hall/car call levels in, scheduler status and clear pulses out.
interface elevator_sched_if;
  logic       press_out1_up;
  logic       press_out2_up;
  logic       press_out2_down;
  logic       press_out3_up;
  logic       press_out3_down;
  logic       press_out4_down;
  logic       press_in1;
  logic       press_in2;
  logic       press_in3;
  logic       press_in4;
  logic [4:0] state;
  logic [1:0] pointer;
  logic [3:0] request_total;
  logic [1:0] cur_floor;
  logic       door_open;
  logic       moving;
  logic [3:0] clear_in;

  modport master (
    output press_out1_up, press_out2_up, press_out2_down, press_out3_up,
           press_out3_down, press_out4_down,
           press_in1, press_in2, press_in3, press_in4,
    input  state, pointer, request_total, cur_floor, door_open, moving, clear_in
  );

  modport slave (
    input  press_out1_up, press_out2_up, press_out2_down, press_out3_up,
           press_out3_down, press_out4_down,
           press_in1, press_in2, press_in3, press_in4,
    output state, pointer, request_total, cur_floor, door_open, moving, clear_in
  );
endinterface

// File: rtl/elevator_sched.sv
// SCAN car-motion scheduler for a 4-floor elevator: merges calls, times
// floor travel and door dwell, and reports target/direction to the latches.
module elevator_sched #(
  parameter int unsigned TRAVEL_CYC = 100000000,
  parameter int unsigned DOOR_CYC   = 150000000,
  parameter int unsigned CNT_W      = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  elevator_sched_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} fsm_e;
  typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_UP = 2'b01, DIR_DOWN = 2'b10} dir_e;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYC - 1);

  fsm_e             fsm_q, fsm_d;
  dir_e             dir_q, dir_d;
  logic [1:0]       cur_q, cur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       req_q, req_d;
  logic [3:0]       clear_q, clear_d;
  logic [4:0]       state_q, state_d;
  logic             door_q, moving_q;
  logic [1:0]       tgt;

  function automatic logic any_above(input logic [3:0] r, input logic [1:0] c);
    logic res;
    res = 1'b0;
    for (int i = 0; i < 4; i++) if (i > int'(c) && r[i]) res = 1'b1;
    return res;
  endfunction

  function automatic logic any_below(input logic [3:0] r, input logic [1:0] c);
    logic res;
    res = 1'b0;
    for (int i = 0; i < 4; i++) if (i < int'(c) && r[i]) res = 1'b1;
    return res;
  endfunction

  function automatic logic [1:0] near_above(input logic [3:0] r, input logic [1:0] c);
    logic [1:0] res;
    res = c;
    for (int i = 3; i >= 0; i--) if (i > int'(c) && r[i]) res = 2'(i);
    return res;
  endfunction

  function automatic logic [1:0] near_below(input logic [3:0] r, input logic [1:0] c);
    logic [1:0] res;
    res = c;
    for (int i = 0; i < 4; i++) if (i < int'(c) && r[i]) res = 2'(i);
    return res;
  endfunction

  // Direction chosen when the door opens at floor c.
  function automatic dir_e dir_at_stop(input logic [3:0] r, input logic [1:0] c,
                                       input dir_e d);
    logic up, dn;
    dir_e res;
    up = any_above(r, c);
    dn = any_below(r, c);
    if (d == DIR_DOWN) res = dn ? DIR_DOWN : (up ? DIR_UP : DIR_NONE);
    else               res = up ? DIR_UP : (dn ? DIR_DOWN : DIR_NONE);
    return res;
  endfunction

  assign req_d = {bus.press_out4_down | bus.press_in4,
                  bus.press_out3_up | bus.press_out3_down | bus.press_in3,
                  bus.press_out2_up | bus.press_out2_down | bus.press_in2,
                  bus.press_out1_up | bus.press_in1};

  always_comb begin
    logic [1:0] nxt;
    fsm_d   = fsm_q;
    dir_d   = dir_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    clear_d = '0;
    nxt     = cur_q;
    unique case (fsm_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_q[cur_q]) begin
          fsm_d          = S_DOOR;
          clear_d[cur_q] = 1'b1;
          dir_d          = dir_at_stop(req_q, cur_q, dir_q);
        end else if (dir_q == DIR_DOWN && any_below(req_q, cur_q)) begin
          fsm_d = S_DOWN;
        end else if (any_above(req_q, cur_q)) begin
          fsm_d = S_UP;
          dir_d = DIR_UP;
        end else if (any_below(req_q, cur_q)) begin
          fsm_d = S_DOWN;
          dir_d = DIR_DOWN;
        end else begin
          dir_d = DIR_NONE;
        end
      end
      S_UP, S_DOWN: begin
        if (cnt_q == TRAVEL_LAST) begin
          nxt   = (fsm_q == S_UP) ? cur_q + 2'd1 : cur_q - 2'd1;
          cur_d = nxt;
          cnt_d = '0;
          // Arrival: serve this floor, keep sweeping, or park.
          if (req_q[nxt]) begin
            fsm_d        = S_DOOR;
            clear_d[nxt] = 1'b1;
            dir_d        = dir_at_stop(req_q, nxt, (fsm_q == S_UP) ? DIR_UP : DIR_DOWN);
          end else if (fsm_q == S_UP ? any_above(req_q, nxt) : any_below(req_q, nxt)) begin
            fsm_d = fsm_q;
          end else begin
            fsm_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DOOR: begin
        if (cnt_q == DOOR_LAST) begin
          fsm_d = S_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Target floor reported alongside the next registered car position.
  always_comb begin
    tgt = cur_d;
    if (fsm_d == S_DOOR || (fsm_d == S_IDLE && req_d[cur_d])) begin
      tgt = cur_d;
    end else if (dir_d == DIR_DOWN) begin
      tgt = any_below(req_d, cur_d) ? near_below(req_d, cur_d) : near_above(req_d, cur_d);
    end else begin
      tgt = any_above(req_d, cur_d) ? near_above(req_d, cur_d) : near_below(req_d, cur_d);
    end
    state_d = (req_d == 4'd0) ? 5'd0 : 5'({tgt, cur_d}) + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= S_IDLE;
      dir_q    <= DIR_NONE;
      cur_q    <= 2'd0;
      cnt_q    <= '0;
      req_q    <= 4'd0;
      clear_q  <= 4'd0;
      state_q  <= 5'd0;
      door_q   <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      dir_q    <= dir_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      clear_q  <= clear_d;
      state_q  <= state_d;
      door_q   <= (fsm_d == S_DOOR);
      moving_q <= (fsm_d == S_UP) || (fsm_d == S_DOWN);
    end
  end

  assign bus.state         = state_q;
  assign bus.pointer       = dir_q;
  assign bus.request_total = req_q;
  assign bus.cur_floor     = cur_q;
  assign bus.door_open     = door_q;
  assign bus.moving        = moving_q;
  assign bus.clear_in      = clear_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Scoreboarded bench: a SCAN stop-order model predicts every door stop.
module tb_elevator_sched;
  localparam int unsigned TRAVEL = 4;
  localparam int unsigned DOOR   = 6;

  typedef struct {
    int         floor;
    logic [1:0] ptr;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_sched_if bus();

  elevator_sched #(.TRAVEL_CYC(TRAVEL), .DOOR_CYC(DOOR), .CNT_W(31)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // press bits: 0 out1_up,1 out2_up,2 out2_down,3 out3_up,4 out3_down,5 out4_down,6..9 in1..in4
  logic [9:0] press_q   = '0;
  logic [9:0] new_press = '0;
  logic       drop_all  = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         model_floor = 0;
  int         door_run = 0;
  exp_t       sb[$];

  assign bus.press_out1_up   = press_q[0];
  assign bus.press_out2_up   = press_q[1];
  assign bus.press_out2_down = press_q[2];
  assign bus.press_out3_up   = press_q[3];
  assign bus.press_out3_down = press_q[4];
  assign bus.press_out4_down = press_q[5];
  assign bus.press_in1       = press_q[6];
  assign bus.press_in2       = press_q[7];
  assign bus.press_in3       = press_q[8];
  assign bus.press_in4       = press_q[9];

  function automatic int bit_floor(input int b);
    int f;
    case (b)
      0: f = 0;
      1, 2: f = 1;
      3, 4: f = 2;
      5: f = 3;
      default: f = b - 6;
    endcase
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Latch-block model: car calls drop on clear_in, hall calls drop while the door is open there.
  always @(posedge clk) begin
    logic [9:0] clr;
    clr = '0;
    for (int k = 0; k < 4; k++) if (bus.clear_in[k]) clr[6+k] = 1'b1;
    if (bus.door_open)
      for (int b = 0; b < 6; b++) if (bit_floor(b) == int'(bus.cur_floor)) clr[b] = 1'b1;
    if (!rst_n || drop_all) press_q <= '0;
    else                    press_q <= (press_q | new_press) & ~clr;
  end

  // Monitor: each clear_in pulse is a door stop and must match the next prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      door_run = 0;
    end else begin
      if (bus.door_open) door_run++;
      else if (door_run != 0) begin
        chk("door_len", door_run, DOOR);
        door_run = 0;
      end
      if (bus.clear_in != 4'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_stop", int'(bus.clear_in), 0);
        end else begin
          e = sb.pop_front();
          chk("stop_floor",  int'(bus.cur_floor), e.floor);
          chk("stop_clear",  int'(bus.clear_in), 1 << e.floor);
          chk("stop_state",  int'(bus.state), 5 * e.floor + 1);
          chk("stop_ptr",    int'(bus.pointer), int'(e.ptr));
          chk("stop_door",   int'(bus.door_open), 1);
          chk("stop_moving", int'(bus.moving), 0);
          chk("stop_cycle",  cyc, e.cyc);
        end
      end
    end
  end

  // Reference: from rest, serve the current floor, then sweep up, then sweep down.
  task automatic plan(input logic [9:0] p, input int n);
    logic [3:0] m;
    int stops[$];
    int prev, d, t, f;
    logic ru, rd;
    exp_t e;
    m = '0;
    for (int b = 0; b < 10; b++) if (p[b]) m[bit_floor(b)] = 1'b1;
    if (m[model_floor]) stops.push_back(model_floor);
    for (int k = model_floor + 1; k < 4; k++) if (m[k]) stops.push_back(k);
    for (int k = model_floor - 1; k >= 0; k--) if (m[k]) stops.push_back(k);
    prev = model_floor;
    t = n + 3;
    for (int i = 0; i < stops.size(); i++) begin
      f = stops[i];
      d = (f > prev) ? 1 : ((f < prev) ? 2 : 0);
      t += 4 * ((f > prev) ? f - prev : prev - f) + ((i == 0) ? 0 : 7);
      ru = 1'b0;
      rd = 1'b0;
      for (int j = i + 1; j < stops.size(); j++) begin
        if (stops[j] > f) ru = 1'b1;
        if (stops[j] < f) rd = 1'b1;
      end
      if (d == 2) e.ptr = rd ? 2'b10 : (ru ? 2'b01 : 2'b00);
      else        e.ptr = ru ? 2'b01 : (rd ? 2'b10 : 2'b00);
      e.floor = f;
      e.cyc   = t;
      sb.push_back(e);
      prev = f;
    end
    model_floor = prev;
  endtask

  task automatic issue(input logic [9:0] p);
    @(negedge clk);
    plan(p, cyc);
    new_press = p;
    @(negedge clk);
    new_press = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 600 && !(sb.size() == 0 && bus.request_total == 4'd0 &&
                        !bus.door_open && !bus.moving)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 600) begin
      chk("idle_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_moving(input logic lvl);
    int k;
    k = 0;
    while (k < 200 && bus.moving != lvl) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("moving_timeout", int'(bus.moving), int'(lvl));
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_ptr", int'(bus.pointer), 0);
    chk("rst_req", int'(bus.request_total), 0);
    chk("rst_floor", int'(bus.cur_floor), 0);
    chk("rst_door", int'(bus.door_open), 0);
    chk("rst_moving", int'(bus.moving), 0);
    chk("rst_clear", int'(bus.clear_in), 0);
    rst_n = 1'b1;
    model_floor = 0;

    // Car call to floor 3 from floor 1.
    issue(10'h100);
    repeat (2) @(negedge clk);
    chk("t1_req", int'(bus.request_total), 4);
    chk("t1_ptr", int'(bus.pointer), 1);
    chk("t1_moving", int'(bus.moving), 1);
    chk("t1_state", int'(bus.state), 9);
    wait_idle();

    issue(10'h040);
    wait_idle();
    issue(10'h022);
    wait_idle();
    issue(10'h100);
    wait_idle();
    issue(10'h240);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      issue(10'($urandom_range(1, 1023)));
      wait_idle();
    end

    // All requests withdrawn mid-segment: arrive without opening the door.
    issue(10'h040);
    wait_idle();
    @(negedge clk);
    new_press = 10'h100;
    @(negedge clk);
    new_press = '0;
    wait_moving(1'b1);
    drop_all = 1'b1;
    @(negedge clk);
    drop_all = 1'b0;
    wait_moving(1'b0);
    repeat (2) @(negedge clk);
    chk("drop_floor", int'(bus.cur_floor), 1);
    chk("drop_door", int'(bus.door_open), 0);
    chk("drop_state", int'(bus.state), 0);
    chk("drop_ptr", int'(bus.pointer), 0);
    chk("drop_req", int'(bus.request_total), 0);
    model_floor = 1;

    // Reset halfway through the door dwell at floor 3.
    issue(10'h100);
    k = 0;
    while (k < 200 && !bus.door_open) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("door_timeout", int'(bus.door_open), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_floor", int'(bus.cur_floor), 0);
    chk("mid_rst_door", int'(bus.door_open), 0);
    chk("mid_rst_state", int'(bus.state), 0);
    chk("mid_rst_ptr", int'(bus.pointer), 0);
    chk("mid_rst_clear", int'(bus.clear_in), 0);
    chk("mid_rst_moving", int'(bus.moving), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    model_floor = 0;

    issue(10'h200);
    wait_idle();
    repeat (10) @(negedge clk);
    chk("leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
